bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the
// 16-bit packed BCD bus consumed by the 7-segment digit-select decoder.
// Accepts a binary count on a start pulse and returns four BCD digits (thousands in [15:12],
// units in [3:0]). Output is register-held between conversions so the scanned display never tears.
// PARAMETERS
// BIN_W   14   width of binary input; max legal value 9999 unless clamping enabled
// DIGITS  4    number of BCD digits; BCD output width = 4*DIGITS
// PORTS
// clk    in   1         system clock, all state on rising edge
// reset  in   1         asynchronous, active-high reset
// start  in   1         request conversion of bin; sampled only in IDLE
// bin    in   BIN_W     binary value, captured on accepted start edge only
// busy   out  1         high while conversion in progress
// done   out  1         single-cycle pulse: BCD/ovf updated this cycle
// BCD    out  4*DIGITS  packed BCD result, held until next completion
// ovf    out  1         input exceeded 10^DIGITS-1 (clamp build only; else tied 0)
// BEHAVIOUR
// - Reset (async assert, any state): state=IDLE, busy=0, done=0, BCD=0, ovf=0, counter=0.
//   Reset mid-conversion aborts it; no done pulse; BCD reads 0.
// - States: IDLE, CONV. IDLE: start=1 at edge k -> latch bin into shift reg, scratch digits=0,
//   bit counter=0, go CONV; busy=1 from edge k.
// - CONV: each edge k+1..k+BIN_W: per digit, if digit>=5 add 3 (4-bit, no carry out), then shift
//   {scratch,shiftreg} left 1; counter++.
// - At edge k+BIN_W (counter reaches BIN_W-1 -> final shift): BCD <= final scratch, done=1,
//   busy=0, state=IDLE. Latency start-edge -> done-edge = BIN_W cycles (14 default).
// - done high exactly one cycle; BCD/ovf stable from that edge until next done or reset.
// - start while busy: ignored, bin not re-sampled. start in the done cycle (IDLE): accepted,
//   busy re-asserts next edge; back-to-back throughput = one result per BIN_W+1 cycles.
// - bin changes during CONV: no effect (captured copy used).
// - Counter width ceil(log2(BIN_W)); no wrap beyond BIN_W-1.
// CONFIGURATION
// BCD_CLAMP_EN defined: on accepted start, bin > 10^DIGITS-1 (9999) -> conversion still runs
//   full latency, but at done BCD = all nines (16'h9999) and ovf=1; in-range input -> ovf=0.
// BCD_CLAMP_EN undefined: no comparator; ovf tied 0; inputs > 9999 are illegal, result undefined,
//   bench must not drive them.
// TESTING
// 1 reset asserted mid-run at any cycle -> busy=0, done=0, BCD=16'h0000 same cycle (async).
// 2 bin=1234, start 1 cycle -> busy 14 cycles, done pulse at edge 14, BCD=16'h1234, holds after.
// 3 bin=0 -> BCD=16'h0000; bin=9999 -> BCD=16'h9999; bin=10 -> BCD=16'h0010; done each once.
// 4 start with bin=42, re-pulse start with bin=77 at cycle 5 -> ignored; result 16'h0042.
// 5 start held high continuously, bin=5 then 6 at accept edges -> results 0005, 0006,
//   done every 15 cycles.
// 6 BCD_CLAMP_EN: bin=12000 -> BCD=16'h9999, ovf=1; next bin=8 -> BCD=16'h0008, ovf=0.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if
// Request/result bundle between a binary-count producer and the sequential
// binary-to-BCD converter.
//   start  producer -> converter   request a conversion of bin
//   bin    producer -> converter   binary value, BIN_W bits
//   busy   converter -> producer   conversion in progress
//   done   converter -> producer   one-cycle pulse, BCD/ovf just updated
//   BCD    converter -> producer   packed BCD result, 4*DIGITS bits
//   ovf    converter -> producer   input exceeded 10^DIGITS-1 (clamp build only)
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   BCD;
    logic                  ovf;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  BCD,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output BCD,
        output ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per
// clock. Feeds the packed BCD bus read by the 7-segment digit-select decoder;
// the result register is only written on completion so the display never tears.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    bin_to_bcd_seq_if.slave (start, bin in; busy, done, BCD, ovf out)
//
// Optional build macro BCD_CLAMP_EN: inputs above 10^DIGITS-1 still take the
// full latency but complete with all-nines and ovf=1. Without it ovf is tied 0
// and out-of-range inputs are not supported.
//
// state | meaning
// IDLE  | waiting for start; result registers hold last value
// CONV  | shifting one bit per clock, BIN_W clocks total
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    bin_to_bcd_seq_if.slave     bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_r;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_nxt;
    logic [BIN_W-1:0]   shreg_nxt;

`ifdef BCD_CLAMP_EN
    localparam int MAX_VAL = (10 ** DIGITS) - 1;
    logic ovf_pend;
    logic ovf_r;
`endif

    // Add-3 correction per digit, then shift {scratch, shreg} left by one.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        scratch_nxt = {adj[BCD_W-2:0], shreg[BIN_W-1]};
        shreg_nxt   = {shreg[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= '0;
`ifdef BCD_CLAMP_EN
            ovf_pend <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        state   <= CONV;
`ifdef BCD_CLAMP_EN
                        ovf_pend <= ({{(32-BIN_W){1'b0}}, bus.bin} > 32'(MAX_VAL));
`endif
                    end
                end
                CONV: begin
                    shreg   <= shreg_nxt;
                    scratch <= scratch_nxt;
                    if (cnt == CNT_LAST) begin
                        // Counter parks at its last value rather than wrapping.
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
`ifdef BCD_CLAMP_EN
                        bcd_r  <= ovf_pend ? {DIGITS{4'h9}} : scratch_nxt;
                        ovf_r  <= ovf_pend;
`else
                        bcd_r  <= scratch_nxt;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.BCD  = bcd_r;
`ifdef BCD_CLAMP_EN
    assign bus.ovf  = ovf_r;
`else
    assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] model_result(input int v);
`ifdef BCD_CLAMP_EN
        if (v > 9999) return 16'h9999;
`endif
        return to_bcd(v);
    endfunction

    function automatic logic model_ovf(input int v);
`ifdef BCD_CLAMP_EN
        return (v > 9999);
`else
        return (v < 0);
`endif
    endfunction

    // Behavioural model: a request is accepted when idle; the result appears
    // 14 clocks later as a one-cycle done with the decimal digits of the value.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_bcd  = '0;
    logic        m_ovf  = 1'b0;
    int          m_left = 0;
    int          m_cap  = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_bcd  <= '0;
            m_ovf  <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_bcd  <= model_result(m_cap);
                    m_ovf  <= model_ovf(m_cap);
                end
            end else if (bus.start) begin
                m_cap  <= int'(bus.bin);
                m_left <= 14;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("busy",  32'(bus.busy), 32'(m_busy));
        chk("done",  32'(bus.done), 32'(m_done));
        chk("bcd",   32'(bus.BCD),  32'(m_bcd));
        chk("ovf",   32'(bus.ovf),  32'(m_ovf));
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 40);
    endtask

    task automatic run_conv(input int v, input logic [15:0] exp_lit, input logic exp_ovf);
        int n;
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.bin   = 14'(v);
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        wait_done(n);
        chk("latency", 32'(n), 32'd14);
        chk("bcd_lit", 32'(bus.BCD), 32'(exp_lit));
        chk("ovf_lit", 32'(bus.ovf), 32'(exp_ovf));
        repeat (3) @(posedge clk);
        #1;
        chk("bcd_hold", 32'(bus.BCD), 32'(exp_lit));
        chk("done_single", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n;
        int t1;
        int t2;
        int dcount;
        bus.start = 1'b0;
        bus.bin   = '0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        #21 reset = 1'b0;

        chk("model_1234", 32'(to_bcd(1234)), 32'h1234);
        chk("model_9999", 32'(to_bcd(9999)), 32'h9999);
        chk("model_10",   32'(to_bcd(10)),   32'h0010);
        @(posedge clk);
        #1;
        chk("reset_bcd", 32'(bus.BCD), 32'h0);

        run_conv(1234, 16'h1234, 1'b0);
        run_conv(0,    16'h0000, 1'b0);
        run_conv(9999, 16'h9999, 1'b0);
        run_conv(10,   16'h0010, 1'b0);

        // Restart while busy must be ignored.
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.bin   = 14'd42;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.bin   = 14'd77;
        n = 0;
        do begin
            if (n == 4) bus.start = 1'b1;
            else bus.start = 1'b0;
            @(posedge clk);
            #1;
            n++;
            #1;
        end while (!bus.done && n < 40);
        bus.start = 1'b0;
        chk("ignore_latency", 32'(n), 32'd14);
        chk("ignore_bcd", 32'(bus.BCD), 32'h0042);
        repeat (3) @(posedge clk);

        // Reset in the middle of a conversion.
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.bin   = 14'd3210;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd",  32'(bus.BCD),  32'h0);
        #4;
        reset = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) dcount++;
        end
        chk("rst_no_done", 32'(dcount), 32'd0);

        // Start held high: back-to-back conversions.
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.bin   = 14'd5;
        @(posedge clk);
        #2;
        bus.bin = 14'd6;
        wait_done(n);
        t1 = cyc;
        chk("b2b_first", 32'(bus.BCD), 32'h0005);
        wait_done(n);
        t2 = cyc;
        bus.start = 1'b0;
        chk("b2b_second", 32'(bus.BCD), 32'h0006);
        chk("b2b_period", 32'(t2 - t1), 32'd15);
        repeat (3) @(posedge clk);

`ifdef BCD_CLAMP_EN
        run_conv(12000, 16'h9999, 1'b1);
        run_conv(8,     16'h0008, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
